// File: rtl/mem_port_arbiter.sv
// Byte-serial RAM port shared between instruction fetch and the MEM stage.
// MEM has fixed priority; transactions are 1/2/4 bytes, little-endian.
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IF_RD  = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_buf_q, rd_buf_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       if_prev_q, if_prev_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic [ADDR_W-1:0] next_addr_s;
  logic [4:0]        wr_idx_s;
  logic [4:0]        rd_idx_s;
  logic [31:0]       rd_word_s;

  // Datapath helpers: next sequential address and byte lane positions.
  always_comb begin
    next_addr_s = ram_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    wr_idx_s    = {k_q[1:0] + 2'd1, 3'b000};
    rd_idx_s    = {k_q[1:0] - 2'd1, 3'b000};
  end

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_dout_d  = ram_dout_q;
    wdata_d     = wdata_q;
    rd_buf_d    = rd_buf_q;
    if_inst_d   = if_inst_q;
    if_prev_d   = if_prev_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    // Byte arriving now belongs to the address issued on the previous cycle.
    rd_word_s   = rd_buf_q;
    rd_word_s[rd_idx_s +: 8] = ram_din;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          state_d    = mem_we ? S_MEM_WR : S_MEM_RD;
          k_d        = 3'd0;
          n_d        = (mem_size == 2'd0) ? 3'd1 : (mem_size == 2'd1) ? 3'd2 : 3'd4;
          ram_addr_d = mem_addr;
          wdata_d    = mem_wdata;
          rd_buf_d   = 32'd0;
          if (mem_we) begin
            ram_we_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            ram_we_d   = 1'b0;
          end
        end else if (if_req && !if_cancel) begin
          state_d    = S_IF_RD;
          k_d        = 3'd0;
          n_d        = 3'd4;
          ram_addr_d = if_addr;
          rd_buf_d   = 32'd0;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_IF_RD, S_MEM_RD: begin
        if (state_q == S_IF_RD && if_cancel) begin
          state_d = S_IDLE;
          k_d     = 3'd0;
        end else if (k_q == n_q) begin
          state_d = S_DONE;
          k_d     = 3'd0;
          if (state_q == S_IF_RD) begin
            if_done_d = 1'b1;
            if_prev_d = if_inst_q;
            if_inst_d = rd_word_s;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = rd_word_s;
          end
        end else begin
          k_d = k_q + 3'd1;
          if (k_q != 3'd0) begin
            rd_buf_d = rd_word_s;
          end else begin
            rd_buf_d = rd_buf_q;
          end
          if (k_q + 3'd1 < n_q) begin
            ram_addr_d = next_addr_s;
          end else begin
            ram_addr_d = ram_addr_q;
          end
        end
      end
      S_MEM_WR: begin
        if (k_q + 3'd1 < n_q) begin
          k_d        = k_q + 3'd1;
          ram_addr_d = next_addr_s;
          ram_dout_d = wdata_q[wr_idx_s +: 8];
        end else begin
          k_d        = 3'd0;
          ram_we_d   = 1'b0;
          state_d    = S_DONE;
          mem_done_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // A flush landing on the IF done cycle retracts the fetched word.
        if (if_done_q && if_cancel) begin
          if_inst_d = if_prev_q;
        end else begin
          if_inst_d = if_inst_q;
        end
      end
      default: begin
        state_d  = S_IDLE;
        k_d      = 3'd0;
        ram_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      wdata_q     <= 32'd0;
      rd_buf_q    <= 32'd0;
      if_inst_q   <= 32'd0;
      if_prev_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_dout_q  <= ram_dout_d;
      wdata_q     <= wdata_d;
      rd_buf_q    <= rd_buf_d;
      if_inst_q   <= if_inst_d;
      if_prev_q   <= if_prev_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_done   = if_done_q & ~if_cancel;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_dout  = ram_dout_q;
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: byte RAM model plus a
// transaction-level reference memory and latency rules.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_cancel, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout, ram_din;
  logic        stall_if, stall_mem;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int if_done_cnt = 0;

  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Synchronous byte RAM: read data appears one cycle after its address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) ram_mem[ram_addr] = ram_dout;
    ram_din <= ram_rd(ram_addr);
  end

  always @(negedge clk) begin
    if (if_done) if_done_cnt <= if_done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic mem_xact(input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
    int n, got, wecnt, stall_bad;
    logic [31:0] exp, ba;
    logic [31:0] seen [4];
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp = 32'd0;
    for (int i = 0; i < n; i++) begin
      ba = a + i;
      exp = exp | ({24'd0, ref_rd(ba)} << (8 * i));
    end
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
    @(negedge clk);
    chk("stall_mem_T", {31'd0, stall_mem}, 32'd1);
    got = -1; wecnt = 0; stall_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i <= n) seen[i-1] = ram_addr;
      if (ram_we) wecnt++;
      if (mem_done) begin
        got = i;
        break;
      end
      if (!stall_mem) stall_bad++;
    end
    chk("mem_latency", got, we ? n + 1 : n + 2);
    chk("stall_mem_hold", stall_bad, 32'd0);
    chk("stall_mem_done", {31'd0, stall_mem}, 32'd0);
    for (int i = 0; i < n; i++) chk("ram_addr_seq", seen[i], a + i);
    if (we) chk("ram_we_cycles", wecnt, n);
    else    chk("mem_rdata", mem_rdata, exp);
    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = 1'b0;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        ba = a + i;
        ref_mem[ba] = wd[8*i +: 8];
        chk("ram_byte", {24'd0, ram_rd(ba)}, {24'd0, ref_rd(ba)});
      end
    end
  endtask

  task automatic if_xact(input logic [31:0] a);
    int got;
    logic [31:0] exp, ba;
    exp = 32'd0;
    for (int i = 0; i < 4; i++) begin
      ba = a + i;
      exp = exp | ({24'd0, ref_rd(ba)} << (8 * i));
    end
    if_req = 1'b1; if_addr = a;
    @(negedge clk);
    chk("stall_if_T", {31'd0, stall_if}, 32'd1);
    got = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (if_done) begin
        got = i;
        break;
      end
    end
    chk("if_latency", got, 32'd6);
    chk("if_inst", if_inst, exp);
    chk("stall_if_done", {31'd0, stall_if}, 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  // Raise IF, flush it in cycle T+cancel_at, and leave the port on the next cycle start.
  task automatic if_cancel_xact(input logic [31:0] a, input int cancel_at);
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < cancel_at; i++) begin
      @(posedge clk); #1;
    end
    if_cancel = 1'b1;
    @(negedge clk);
    chk("if_done_cancel", {31'd0, if_done}, 32'd0);
    @(posedge clk); #1;
    if_cancel = 1'b0; if_req = 1'b0;
  endtask

  initial begin
    logic [31:0] old_inst, a;
    int t0, got, cnt0, kind;
    rst = 1'b1; if_req = 1'b0; if_cancel = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    @(posedge clk); #1;

    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    for (int i = 0; i < 16; i++) poke(32'h400 + i, 8'($urandom_range(0, 255)));
    poke(32'hFFFFFFFE, 8'hA5); poke(32'hFFFFFFFF, 8'h5A);
    poke(32'h0, 8'hC3); poke(32'h1, 8'h3C);

    mem_xact(1'b0, 2'd2, 32'h100, 32'd0);
    chk("word_load_value", mem_rdata, 32'h44332211);

    mem_xact(1'b1, 2'd1, 32'h1FF, 32'hAABBCCDD);
    chk("half_store_1ff", {24'd0, ram_rd(32'h1FF)}, 32'hDD);
    chk("half_store_200", {24'd0, ram_rd(32'h200)}, 32'hCC);

    // MEM and IF together: MEM first, IF accepted in the IDLE after MEM's done.
    t0 = cyc; cnt0 = if_done_cnt;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h404;
    got = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_done) begin
        got = cyc - t0;
        break;
      end
    end
    chk("arb_mem_latency", got, 32'd6);
    chk("arb_mem_rdata", mem_rdata, 32'h44332211);
    chk("arb_if_not_first", if_done_cnt - cnt0, 32'd0);
    @(posedge clk); #1;
    mem_req = 1'b0;
    got = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_done) begin
        got = cyc - t0;
        break;
      end
    end
    chk("arb_if_latency", got, 32'd13);
    chk("arb_if_inst", if_inst, {ref_rd(32'h407), ref_rd(32'h406), ref_rd(32'h405), ref_rd(32'h404)});
    @(posedge clk); #1;
    if_req = 1'b0;

    // Flush in the 3rd IF_RD cycle; MEM raised right after must start at once.
    old_inst = if_inst; cnt0 = if_done_cnt;
    if_cancel_xact(32'h408, 3);
    mem_xact(1'b0, 2'd0, 32'h400, 32'd0);
    chk("cancel_no_done", if_done_cnt - cnt0, 32'd0);
    chk("cancel_inst_kept", if_inst, old_inst);

    // Flush landing on the IF done cycle.
    old_inst = if_inst; cnt0 = if_done_cnt;
    if_cancel_xact(32'h40C, 6);
    mem_xact(1'b0, 2'd1, 32'h402, 32'd0);
    chk("cancel_done_no_pulse", if_done_cnt - cnt0, 32'd0);
    chk("cancel_done_inst_kept", if_inst, old_inst);

    mem_xact(1'b0, 2'd0, 32'hFFFFFFFF, 32'd0);
    chk("wrap_byte", mem_rdata, 32'h0000005A);
    mem_xact(1'b0, 2'd2, 32'hFFFFFFFE, 32'd0);
    chk("wrap_word", mem_rdata, 32'h3CC35AA5);

    // Reset two cycles into a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = 32'h55667788;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rstmid_ram_addr", ram_addr, 32'd0);
    chk("rstmid_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rstmid_mem_rdata", mem_rdata, 32'd0);
    chk("rstmid_if_inst", if_inst, 32'd0);
    @(posedge clk); #1;
    chk("rstmid_b0", {24'd0, ram_rd(32'h300)}, 32'h88);
    chk("rstmid_b1", {24'd0, ram_rd(32'h301)}, 32'h77);
    chk("rstmid_b2", {24'd0, ram_rd(32'h302)}, 32'h00);
    chk("rstmid_b3", {24'd0, ram_rd(32'h303)}, 32'h00);
    ref_mem[32'h300] = 8'h88; ref_mem[32'h301] = 8'h77;
    mem_xact(1'b0, 2'd2, 32'h300, 32'd0);

    // Randomized mix of loads, stores and fetches against the reference memory.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 3);
      else a = 32'h400 + $urandom_range(0, 15);
      case (kind)
        0: mem_xact(1'b0, 2'($urandom_range(0, 3)), a, 32'd0);
        1: mem_xact(1'b1, 2'($urandom_range(0, 3)), a, $urandom);
        default: if_xact(a);
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
